debug_host_ctrl: RTL and testbench

- Byte-stream debug command sequencer; initiator end of the core's coprocessor debug port (address/control/data-in/data-out).
- Accepts command bytes from a host link (UART bridge or testbench), halts/resumes the core, reads and writes GPRs, reads CSRs.
- Returns results as a byte stream.
- Sits between the host-link byte FIFO and the datapath debug port.

---
 rtl/debug_host_ctrl_if.sv | 33 +++
 rtl/debug_host_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_debug_host_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_host_ctrl_if.sv
// Host-link byte streams plus the coprocessor debug port of debug_host_ctrl.
//   master : the command sequencer (takes cmd bytes, returns rsp bytes, drives the debug port)
//   slave  : host link and core datapath side
//   cmd_valid/cmd_data/cmd_ready   host -> controller command bytes
//   rsp_valid/rsp_data/rsp_ready   controller -> host response bytes
//   coprocessorIOAddr/Control/DataOut  debug access issued to the core
//   coprocessorIODataIn            combinational read data from the addressed GPR/CSR
interface debug_host_ctrl_if #(
  parameter int unsigned N = 64
) ();
  logic          cmd_valid;
  logic [7:0]    cmd_data;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [7:0]    rsp_data;
  logic          rsp_ready;
  logic [14:0]   coprocessorIOAddr;
  logic [4:0]    coprocessorIOControl;
  logic [N-1:0]  coprocessorIODataOut;
  logic [N-1:0]  coprocessorIODataIn;

  modport master (
    input  cmd_valid, cmd_data, rsp_ready, coprocessorIODataIn,
    output cmd_ready, rsp_valid, rsp_data,
           coprocessorIOAddr, coprocessorIOControl, coprocessorIODataOut
  );

  modport slave (
    output cmd_valid, cmd_data, rsp_ready, coprocessorIODataIn,
    input  cmd_ready, rsp_valid, rsp_data,
           coprocessorIOAddr, coprocessorIOControl, coprocessorIODataOut
  );
endinterface

// File: rtl/debug_host_ctrl.sv
// Byte-stream debug command sequencer: decodes host command bytes, halts/resumes
// the core, performs single-cycle GPR read/write and CSR read accesses on the
// coprocessor debug port, and streams results back as bytes (LSB first).
//   clk, reset : clock, synchronous active-high reset
//   dbg        : host cmd/rsp byte streams and debug port (master side)
//   halted     : mirror of the halt flag
module debug_host_ctrl #(
  parameter int unsigned N        = 64,
  parameter logic [7:0]  ACK_CODE = 8'hA5,
  parameter logic [7:0]  ERR_CODE = 8'hEE
) (
  input  logic              clk,
  input  logic              reset,
  debug_host_ctrl_if.master dbg,
  output logic              halted
);

  localparam int unsigned BYTES = N / 8;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

  localparam logic [7:0] OP_HALT      = 8'h01;
  localparam logic [7:0] OP_RESUME    = 8'h02;
  localparam logic [7:0] OP_READ_REG  = 8'h10;
  localparam logic [7:0] OP_WRITE_REG = 8'h11;
  localparam logic [7:0] OP_READ_CSR  = 8'h20;

  localparam logic [4:0] CTRL_RD_GPR = 5'b00110;
  localparam logic [4:0] CTRL_RD_CSR = 5'b01110;
  localparam logic [4:0] CTRL_WR_GPR = 5'b00101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR0,
    S_GET_ADDR1,
    S_GET_DATA,
    S_ACCESS,
    S_SEND,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [11:0]      addr_q, addr_d;
  logic [N-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [14:0]      io_addr_q, io_addr_d;
  logic [4:0]       io_ctrl_q, io_ctrl_d;
  logic [N-1:0]     io_dout_q, io_dout_d;

  logic             cmd_fire_c;
  logic             rsp_fire_c;
  logic [N-1:0]     data_shift_c;
  logic             operands_done_c;
  logic             enter_access_c;

  assign cmd_fire_c   = dbg.cmd_valid && cmd_ready_q;
  assign rsp_fire_c   = rsp_valid_q && dbg.rsp_ready;
  assign data_shift_c = data_q >> 8;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      halt_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      io_addr_q   <= '0;
      io_ctrl_q   <= '0;
      io_dout_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      halt_q      <= halt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      io_addr_q   <= io_addr_d;
      io_ctrl_q   <= io_ctrl_d;
      io_dout_q   <= io_dout_d;
    end
  end

  // Next-state and registered-output lookahead
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    addr_d          = addr_q;
    data_d          = data_q;
    cnt_d           = cnt_q;
    halt_d          = halt_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_data_d      = rsp_data_q;
    io_addr_d       = io_addr_q;
    io_ctrl_d       = io_ctrl_q;
    io_dout_d       = io_dout_q;
    cmd_ready_d     = 1'b0;
    operands_done_c = 1'b0;
    enter_access_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire_c) begin
          op_d  = dbg.cmd_data;
          cnt_d = '0;
          case (dbg.cmd_data)
            OP_HALT: begin
              halt_d      = 1'b1;
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = ACK_CODE;
            end
            OP_RESUME: begin
              halt_d      = 1'b0;
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = ACK_CODE;
            end
            OP_READ_REG, OP_WRITE_REG, OP_READ_CSR: begin
              state_d = S_GET_ADDR0;
            end
            default: begin
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = ERR_CODE;
            end
          endcase
        end
      end
      S_GET_ADDR0: begin
        if (cmd_fire_c) begin
          addr_d[7:0] = dbg.cmd_data;
          case (op_q)
            OP_WRITE_REG: state_d = S_GET_DATA;
            OP_READ_CSR:  state_d = S_GET_ADDR1;
            default:      operands_done_c = 1'b1;
          endcase
        end
      end
      S_GET_ADDR1: begin
        // Only the low nibble of the high address byte is meaningful.
        if (cmd_fire_c) begin
          addr_d[11:8]    = dbg.cmd_data[3:0];
          operands_done_c = 1'b1;
        end
      end
      S_GET_DATA: begin
        if (cmd_fire_c) begin
          data_d[8*int'(cnt_q) +: 8] = dbg.cmd_data;
          if (cnt_q == CNT_LAST) begin
            cnt_d           = '0;
            operands_done_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_ACCESS: begin
        if (op_q == OP_WRITE_REG) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ACK_CODE;
        end else begin
          data_d      = dbg.coprocessorIODataIn;
          rsp_data_d  = dbg.coprocessorIODataIn[7:0];
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        // rsp_data_q already shows byte cnt_q; the shifter holds the bytes still to go.
        if (rsp_fire_c) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d       = '0;
            rsp_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            data_d     = data_shift_c;
            rsp_data_d = data_shift_c[7:0];
          end
        end
      end
      S_RESP: begin
        if (rsp_fire_c) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Operands always fully consumed so the host stream stays framed; access only when halted.
    if (operands_done_c) begin
      if (halt_q) begin
        state_d        = S_ACCESS;
        enter_access_c = 1'b1;
      end else begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = ERR_CODE;
      end
    end

    // Debug port: access controls for exactly the ACCESS cycle, halt hold otherwise.
    if (enter_access_c) begin
      case (op_q)
        OP_READ_CSR: begin
          io_addr_d = {3'b000, addr_d};
          io_ctrl_d = CTRL_RD_CSR;
        end
        OP_WRITE_REG: begin
          io_addr_d = {10'd0, addr_d[4:0]};
          io_ctrl_d = CTRL_WR_GPR;
          io_dout_d = data_d;
        end
        default: begin
          io_addr_d = {10'd0, addr_d[4:0]};
          io_ctrl_d = CTRL_RD_GPR;
        end
      endcase
    end else begin
      io_ctrl_d = {2'b00, halt_d, 2'b00};
    end

    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_GET_ADDR0) ||
                  (state_d == S_GET_ADDR1) || (state_d == S_GET_DATA);
  end

  assign dbg.cmd_ready            = cmd_ready_q;
  assign dbg.rsp_valid            = rsp_valid_q;
  assign dbg.rsp_data             = rsp_data_q;
  assign dbg.coprocessorIOAddr    = io_addr_q;
  assign dbg.coprocessorIOControl = io_ctrl_q;
  assign dbg.coprocessorIODataOut = io_dout_q;
  assign halted                   = halt_q;

endmodule

// File: tb/tb_debug_host_ctrl.sv
// Self-checking bench for debug_host_ctrl: directed and randomized command
// streams checked against a transaction-level model of the command protocol.
module tb_debug_host_ctrl;

  localparam int unsigned N     = 64;
  localparam int unsigned BYTES = N / 8;
  localparam logic [7:0]  ACK   = 8'hA5;
  localparam logic [7:0]  ERR   = 8'hEE;

  typedef struct packed {
    logic [14:0] addr;
    logic [4:0]  ctrl;
    logic [63:0] dout;
  } acc_t;

  logic clk = 1'b0;
  logic reset;
  logic halted;

  debug_host_ctrl_if #(.N(N)) dbg ();

  debug_host_ctrl #(.N(N), .ACK_CODE(ACK), .ERR_CODE(ERR)) dut (
    .clk    (clk),
    .reset  (reset),
    .dbg    (dbg),
    .halted (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Environment: register file (x0 discards writes) and a fixed CSR pattern.
  logic [63:0] env_gpr [32] = '{default: 64'h0};

  function automatic logic [63:0] csr_val(input logic [11:0] a);
    return {20'hC5C00, a, 32'h9E3779B9 ^ {20'h0, a}};
  endfunction

  assign dbg.coprocessorIODataIn = dbg.coprocessorIOControl[3] ?
                                   csr_val(dbg.coprocessorIOAddr[11:0]) :
                                   env_gpr[dbg.coprocessorIOAddr[4:0]];

  // Response backpressure: random unless forced.
  logic rand_rdy = 1'b1;
  logic force_hi = 1'b0;
  logic force_lo = 1'b0;
  always @(negedge clk) rand_rdy <= ($urandom_range(0, 3) != 0);
  assign dbg.rsp_ready = force_lo ? 1'b0 : (force_hi ? 1'b1 : rand_rdy);

  // Observers: debug accesses, transferred response bytes, rsp hold stability.
  acc_t        acc_q[$];
  logic [7:0]  rsp_q[$];
  int          hold_viol = 0;
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_byte = 8'h0;

  always @(posedge clk) begin
    if (dbg.coprocessorIOControl[1:0] != 2'b00)
      acc_q.push_back({dbg.coprocessorIOAddr, dbg.coprocessorIOControl, dbg.coprocessorIODataOut});
    if (dbg.coprocessorIOControl[0] && dbg.coprocessorIOAddr[4:0] != 5'd0)
      env_gpr[dbg.coprocessorIOAddr[4:0]] <= dbg.coprocessorIODataOut;
    if (dbg.rsp_valid && dbg.rsp_ready)
      rsp_q.push_back(dbg.rsp_data);
    if (hold_pend && !reset && !(dbg.rsp_valid && dbg.rsp_data == hold_byte))
      hold_viol <= hold_viol + 1;
    hold_pend <= dbg.rsp_valid && !dbg.rsp_ready && !reset;
    hold_byte <= dbg.rsp_data;
  end

  // Reference model state
  bit          m_halt = 1'b0;
  logic [63:0] m_gpr [32] = '{default: 64'h0};

  // Present one command byte; called and returns on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    dbg.cmd_valid = 1'b1;
    dbg.cmd_data  = b;
    for (int i = 0; i < 100 && !done; i++) begin
      if (dbg.cmd_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    dbg.cmd_valid = 1'b0;
    if (!done) check_eq("cmd_accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_cmd(input logic [7:0] b[$]);
    logic [7:0]  exp_rsp[$];
    bit          has_acc;
    acc_t        exp_acc;
    acc_t        got;
    logic [4:0]  gi;
    logic [11:0] ca;
    logic [63:0] w;
    logic [7:0]  op;
    int          lat;
    int          waited;
    has_acc = 1'b0;
    exp_acc = '0;
    w       = '0;
    op      = b[0];
    case (op)
      8'h01: begin m_halt = 1'b1; exp_rsp.push_back(ACK); end
      8'h02: begin m_halt = 1'b0; exp_rsp.push_back(ACK); end
      8'h10: begin
        gi = b[1][4:0];
        if (m_halt) begin
          has_acc = 1'b1;
          exp_acc = {15'(gi), 5'b00110, 64'h0};
          w = (gi == 5'd0) ? 64'h0 : m_gpr[gi];
          for (int k = 0; k < int'(BYTES); k++) exp_rsp.push_back(w[8*k +: 8]);
        end else exp_rsp.push_back(ERR);
      end
      8'h11: begin
        gi = b[1][4:0];
        for (int k = 0; k < int'(BYTES); k++) w[8*k +: 8] = b[2+k];
        if (m_halt) begin
          has_acc = 1'b1;
          exp_acc = {15'(gi), 5'b00101, w};
          exp_rsp.push_back(ACK);
          if (gi != 5'd0) m_gpr[gi] = w;
        end else exp_rsp.push_back(ERR);
      end
      8'h20: begin
        ca = {b[2][3:0], b[1]};
        if (m_halt) begin
          has_acc = 1'b1;
          exp_acc = {15'(ca), 5'b01110, 64'h0};
          w = csr_val(ca);
          for (int k = 0; k < int'(BYTES); k++) exp_rsp.push_back(w[8*k +: 8]);
        end else exp_rsp.push_back(ERR);
      end
      default: exp_rsp.push_back(ERR);
    endcase

    acc_q.delete();
    rsp_q.delete();
    foreach (b[i]) send_byte(b[i]);

    lat = 0;
    while (!dbg.rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq($sformatf("op%02h_latency", op), 64'(lat), has_acc ? 64'd1 : 64'd0);

    waited = 0;
    while (rsp_q.size() < exp_rsp.size() && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check_eq($sformatf("op%02h_rsp_count", op), 64'(rsp_q.size()), 64'(exp_rsp.size()));
    foreach (exp_rsp[i])
      if (i < rsp_q.size())
        check_eq($sformatf("op%02h_rsp_byte%0d", op, i), 64'(rsp_q[i]), 64'(exp_rsp[i]));

    check_eq($sformatf("op%02h_access_count", op), 64'(acc_q.size()), 64'(has_acc));
    if (has_acc && acc_q.size() > 0) begin
      got = acc_q[0];
      check_eq($sformatf("op%02h_access_addr", op), 64'(got.addr), 64'(exp_acc.addr));
      check_eq($sformatf("op%02h_access_ctrl", op), 64'(got.ctrl), 64'(exp_acc.ctrl));
      if (exp_acc.ctrl[0])
        check_eq($sformatf("op%02h_access_dout", op), got.dout, exp_acc.dout);
    end

    @(negedge clk);
    check_eq($sformatf("op%02h_rsp_valid_idle", op), 64'(dbg.rsp_valid), 64'd0);
    check_eq($sformatf("op%02h_halted", op), 64'(halted), 64'(m_halt));
    check_eq($sformatf("op%02h_ctrl_idle", op), 64'(dbg.coprocessorIOControl), 64'({2'b00, m_halt, 2'b00}));
    check_eq($sformatf("op%02h_cmd_ready", op), 64'(dbg.cmd_ready), 64'd1);
  endtask

  task automatic cmd1(input logic [7:0] op);
    logic [7:0] q[$];
    q.push_back(op);
    run_cmd(q);
  endtask

  task automatic cmd2(input logic [7:0] op, input logic [7:0] a0);
    logic [7:0] q[$];
    q.push_back(op); q.push_back(a0);
    run_cmd(q);
  endtask

  task automatic cmd3(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1);
    logic [7:0] q[$];
    q.push_back(op); q.push_back(a0); q.push_back(a1);
    run_cmd(q);
  endtask

  task automatic cmdw(input logic [7:0] a0, input logic [63:0] d);
    logic [7:0] q[$];
    q.push_back(8'h11); q.push_back(a0);
    for (int k = 0; k < int'(BYTES); k++) q.push_back(d[8*k +: 8]);
    run_cmd(q);
  endtask

  // Read of GPR 5 with three cycles of rsp backpressure on the second byte.
  task automatic hold_test();
    logic [63:0] w;
    int waited;
    w = m_gpr[5];
    force_hi = 1'b1;
    rsp_q.delete();
    send_byte(8'h10);
    send_byte(8'h05);
    waited = 0;
    while (rsp_q.size() < 1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    force_lo = 1'b1;
    check_eq("hold_first_byte", 64'(rsp_q.size()), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("hold_valid%0d", i), 64'(dbg.rsp_valid), 64'd1);
      check_eq($sformatf("hold_data%0d", i), 64'(dbg.rsp_data), 64'h77);
      @(negedge clk);
    end
    force_lo = 1'b0;
    waited = 0;
    while (rsp_q.size() < int'(BYTES) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("hold_rsp_count", 64'(rsp_q.size()), 64'(BYTES));
    for (int k = 0; k < int'(BYTES); k++)
      if (k < rsp_q.size())
        check_eq($sformatf("hold_rsp_byte%0d", k), 64'(rsp_q[k]), 64'(w[8*k +: 8]));
    force_hi = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  u;
    logic [63:0] d;
    int          kind;

    reset = 1'b1;
    dbg.cmd_valid = 1'b0;
    dbg.cmd_data  = 8'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", 64'(dbg.cmd_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(dbg.rsp_valid), 64'd0);
    check_eq("rst_rsp_data", 64'(dbg.rsp_data), 64'd0);
    check_eq("rst_addr", 64'(dbg.coprocessorIOAddr), 64'd0);
    check_eq("rst_dout", dbg.coprocessorIODataOut, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_cmd_ready", 64'(dbg.cmd_ready), 64'd1);
    repeat (4) @(negedge clk);
    check_eq("idle_ctrl", 64'(dbg.coprocessorIOControl), 64'd0);
    check_eq("idle_rsp_valid", 64'(dbg.rsp_valid), 64'd0);
    check_eq("idle_halted", 64'(halted), 64'd0);
    check_eq("idle_cmd_ready", 64'(dbg.cmd_ready), 64'd1);

    // Halt/resume, including redundant ones.
    cmd1(8'h01);
    cmd1(8'h01);
    cmd1(8'h02);
    cmd1(8'h02);
    cmd1(8'h01);

    // Halted register and CSR traffic.
    cmdw(8'h05, 64'h1122334455667788);
    hold_test();
    cmd2(8'h10, 8'h05);
    cmd3(8'h20, 8'h05, 8'h03);
    cmd3(8'h20, 8'hFF, 8'hFF);
    cmdw(8'h00, 64'hDEADBEEFCAFEF00D);
    cmd2(8'h10, 8'h00);
    cmd2(8'h10, 8'hE5);

    // Running: operand bytes consumed, rejected.
    cmd1(8'h02);
    cmd2(8'h10, 8'h03);
    cmd3(8'h20, 8'h10, 8'h00);
    cmdw(8'h06, 64'h0102030405060708);
    cmd1(8'h7F);
    cmd1(8'h00);
    cmd1(8'hFF);

    // Randomized command mix.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 9:    cmd1(8'h01);
        1:       cmd1(8'h02);
        2, 3:    cmd2(8'h10, 8'($urandom));
        4, 5: begin
          d = {32'($urandom), 32'($urandom)};
          cmdw(8'($urandom_range(0, 31)), d);
        end
        6, 7:    cmd3(8'h20, 8'($urandom), 8'($urandom));
        default: begin
          do u = 8'($urandom); while (u inside {8'h01, 8'h02, 8'h10, 8'h11, 8'h20});
          cmd1(u);
        end
      endcase
    end

    // Reset in the middle of a WRITE_REG data phase.
    cmd1(8'h01);
    acc_q.delete();
    rsp_q.delete();
    send_byte(8'h11);
    send_byte(8'h07);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_halt = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_access_count", 64'(acc_q.size()), 64'd0);
    check_eq("abort_rsp_count", 64'(rsp_q.size()), 64'd0);
    check_eq("abort_halted", 64'(halted), 64'd0);
    check_eq("abort_ctrl", 64'(dbg.coprocessorIOControl), 64'd0);
    check_eq("abort_rsp_valid", 64'(dbg.rsp_valid), 64'd0);
    check_eq("abort_cmd_ready", 64'(dbg.cmd_ready), 64'd1);
    cmd1(8'h01);
    cmd2(8'h10, 8'h07);

    check_eq("rsp_hold_violations", 64'(hold_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
